// File: rtl/high_speed_bus_ecc_pkg.sv
// Shared SECDED(39,32) definitions: sizes, the data-to-position map, and the
// encode/syndrome functions used by both the transmit encoder and checkers.
package high_speed_bus_ecc_pkg;

   localparam int DATA_W = 32;
   localparam int CHK_W  = 7;
   localparam int CODE_W = 39;
   localparam int SYN_W  = CHK_W - 1;

   // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two position.
   function automatic int data_pos(input int idx);
      int n;
      int pos;
      n   = 0;
      pos = 0;
      for (int p = 1; p < CODE_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == idx) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

   // Positions covered by check bit 2^k (bit p-1 set when p has bit k set).
   function automatic logic [CODE_W-1:0] chk_mask(input int k);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int p = 1; p < CODE_W; p++) m[p-1] = p[k];
      return m;
   endfunction

   function automatic logic [SYN_W-1:0] secded_syndrome(input logic [CODE_W-1:0] code);
      logic [SYN_W-1:0] s;
      s = '0;
      for (int k = 0; k < SYN_W; k++) s[k] = ^(code & chk_mask(k));
      return s;
   endfunction

   // Check bits are the syndrome of the data-only word, so the final syndrome is zero.
   function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
      logic [CODE_W-1:0] code;
      logic [SYN_W-1:0]  s;
      code = '0;
      for (int d = 0; d < DATA_W; d++) code[data_pos(d)-1] = data[d];
      s = secded_syndrome(code);
      for (int k = 0; k < SYN_W; k++) code[(1 << k) - 1] = s[k];
      code[CODE_W-1] = ^code[CODE_W-2:0];
      return code;
   endfunction

endpackage

// File: rtl/high_speed_bus_ecc_check.sv
// Combinational SECDED(39,32) checker: Hamming syndrome plus overall parity.
// Shared with the receive-side decoder.
module secded_39_32_check
   import high_speed_bus_ecc_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [SYN_W-1:0]  syndrome,
   output logic              parity_err
);

   genvar gi;
   generate
      for (gi = 0; gi < SYN_W; gi++) begin : g_syn
         assign syndrome[gi] = ^(code & chk_mask(gi));
      end
   endgenerate

   assign parity_err = ^code;

endmodule

// File: rtl/high_speed_bus_ecc.sv
// Registered SECDED encoder for the transmit bus with a built-in checker that
// re-decodes the launched codeword to catch corruption in the output flop.
module high_speed_bus_ecc
   import high_speed_bus_ecc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_in,
   output logic [CODE_W-1:0] data_out,
   output logic              ecc_error
);

   logic [CODE_W-1:0] data_out_reg;
   logic              ecc_error_reg;
   logic              ecc_error_next;
   logic [SYN_W-1:0]  syndrome;
   logic              parity_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_reg <= '0;
      end else if (valid) begin
         data_out_reg <= secded_encode(data_in);
      end
   end

   secded_39_32_check u_check (
      .code       (data_out_reg),
      .syndrome   (syndrome),
      .parity_err (parity_err)
   );

   assign ecc_error_next = (syndrome != '0) | parity_err;

   // Checker result is evaluated every cycle, one cycle behind the launched word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ecc_error_reg <= 1'b0;
      end else begin
         ecc_error_reg <= ecc_error_next;
      end
   end

   assign data_out  = data_out_reg;
   assign ecc_error = ecc_error_reg;

endmodule

// File: tb/tb_high_speed_bus_ecc.sv
// Self-checking bench for high_speed_bus_ecc against a position-arithmetic SECDED model.
module tb_high_speed_bus_ecc;

   logic        clk;
   logic        reset_n;
   logic        valid;
   logic [31:0] data_in;
   logic [38:0] data_out;
   logic        ecc_error;

   int total;
   int bad;

   logic [38:0] forced;

   high_speed_bus_ecc dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid     (valid),
      .data_in   (data_in),
      .data_out  (data_out),
      .ecc_error (ecc_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Syndrome = XOR of the positions of all set bits in positions 1..38.
   function automatic logic [5:0] ref_syndrome(input logic [38:0] c);
      int s;
      s = 0;
      for (int p = 1; p <= 38; p++) if (c[p-1]) s ^= p;
      return s[5:0];
   endfunction

   function automatic logic [38:0] ref_encode(input logic [31:0] d);
      logic [38:0] c;
      int idx;
      int s;
      c = '0;
      idx = 0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            c[p-1] = d[idx];
            idx++;
         end
      end
      s = ref_syndrome(c);
      for (int k = 0; k < 6; k++) c[(1 << k) - 1] = s[k];
      c[38] = ^c[37:0];
      return c;
   endfunction

   function automatic logic [31:0] ref_extract(input logic [38:0] c);
      logic [31:0] d;
      int idx;
      d = '0;
      idx = 0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            d[idx] = c[p-1];
            idx++;
         end
      end
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      valid   = 1'b1;
      data_in = 32'hFFFF_FFFF;
      step();
      step();
      total++;
      if (data_out !== 39'h0) begin
         bad++;
         $display("FAIL reset_data_out got=%h want=%h", data_out, 39'h0);
      end
      total++;
      if (ecc_error !== 1'b0) begin
         bad++;
         $display("FAIL reset_ecc_error got=%b want=0", ecc_error);
      end
      $display("reset: data_out=%h ecc_error=%b", data_out, ecc_error);
   endtask

   task automatic test_zero();
      reset_n = 1'b1;
      valid   = 1'b1;
      data_in = 32'h0;
      step();
      total++;
      if (data_out !== 39'h0) begin
         bad++;
         $display("FAIL zero_data_out got=%h want=%h", data_out, 39'h0);
      end
      step();
      total++;
      if (ecc_error !== 1'b0) begin
         bad++;
         $display("FAIL zero_ecc_error got=%b want=0", ecc_error);
      end
      $display("zero: data_in=%h data_out=%h", data_in, data_out);
   endtask

   task automatic test_all_ones();
      valid   = 1'b1;
      data_in = 32'hFFFF_FFFF;
      step();
      total++;
      if (data_out !== 39'h3F_7FFF_FFF4) begin
         bad++;
         $display("FAIL ones_data_out got=%h want=%h", data_out, 39'h3F_7FFF_FFF4);
      end
      total++;
      if (data_out !== ref_encode(32'hFFFF_FFFF)) begin
         bad++;
         $display("FAIL ones_model got=%h want=%h", data_out, ref_encode(32'hFFFF_FFFF));
      end
      $display("ones: data_in=%h data_out=%h", data_in, data_out);
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [8];
      logic [38:0] exp;
      words = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h87654321,
                32'hDEADBEEF, 32'hCAFEBABE, 32'h0F0F0F0F, 32'hF0F0F0F0};
      for (int i = 0; i < 8; i++) begin
         valid   = 1'b1;
         data_in = words[i];
         step();
         exp = ref_encode(words[i]);
         total++;
         if (data_out !== exp) begin
            bad++;
            $display("FAIL b2b_data_out[%0d] got=%h want=%h", i, data_out, exp);
         end
         total++;
         if (ref_extract(data_out) !== words[i]) begin
            bad++;
            $display("FAIL b2b_extract[%0d] got=%h want=%h", i, ref_extract(data_out), words[i]);
         end
         total++;
         if (dut.syndrome !== 6'd0) begin
            bad++;
            $display("FAIL b2b_syndrome[%0d] got=%h want=0", i, dut.syndrome);
         end
         total++;
         if (ecc_error !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ecc_error[%0d] got=%b want=0", i, ecc_error);
         end
         $display("b2b: data_in=%h data_out=%h ecc_error=%b", words[i], data_out, ecc_error);
      end
   endtask

   task automatic test_hold();
      logic [38:0] exp;
      exp   = ref_encode(32'hF0F0F0F0);
      valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_in = $urandom;
         step();
         total++;
         if (data_out !== exp) begin
            bad++;
            $display("FAIL hold_data_out[%0d] got=%h want=%h", i, data_out, exp);
         end
         $display("hold: data_in=%h data_out=%h", data_in, data_out);
      end
   endtask

   task automatic test_random();
      logic [38:0] exp;
      exp = data_out;
      for (int i = 0; i < 30; i++) begin
         valid   = 1'($urandom_range(0, 1));
         data_in = $urandom;
         if (valid) exp = ref_encode(data_in);
         step();
         total++;
         if (data_out !== exp) begin
            bad++;
            $display("FAIL rand_data_out[%0d] got=%h want=%h", i, data_out, exp);
         end
         total++;
         if (ecc_error !== 1'b0) begin
            bad++;
            $display("FAIL rand_ecc_error[%0d] got=%b want=0", i, ecc_error);
         end
         $display("rand: valid=%b data_in=%h data_out=%h", valid, data_in, data_out);
      end
   endtask

   task automatic test_force();
      int bits [5];
      int b;
      logic [5:0] exp_syn;
      bits = '{0, 2, 20, 37, 38};
      bits[1] = $urandom_range(0, 38);
      for (int i = 0; i < 5; i++) begin
         b = bits[i];
         valid  = 1'b0;
         forced = data_out ^ (39'h1 << b);
         force dut.data_out_reg = forced;
         #1;
         exp_syn = (b < 38) ? 6'(b + 1) : 6'd0;
         total++;
         if (dut.syndrome !== exp_syn) begin
            bad++;
            $display("FAIL force_syndrome bit=%0d got=%0d want=%0d", b, dut.syndrome, exp_syn);
         end
         step();
         total++;
         if (ecc_error !== 1'b1) begin
            bad++;
            $display("FAIL force_ecc_error bit=%0d got=%b want=1", b, ecc_error);
         end
         release dut.data_out_reg;
         valid   = 1'b1;
         data_in = $urandom;
         step();
         valid = 1'b0;
         step();
         total++;
         if (ecc_error !== 1'b0) begin
            bad++;
            $display("FAIL force_recover bit=%0d got=%b want=0", b, ecc_error);
         end
         $display("force: bit=%0d syndrome=%0d recovered ecc_error=%b", b, exp_syn, ecc_error);
      end
   endtask

   task automatic test_midstream_reset();
      logic [31:0] w;
      valid   = 1'b1;
      data_in = 32'h13579BDF;
      step();
      reset_n = 1'b0;
      #1;
      total++;
      if (data_out !== 39'h0 || ecc_error !== 1'b0) begin
         bad++;
         $display("FAIL midreset got=%h/%b want=0/0", data_out, ecc_error);
      end
      step();
      reset_n = 1'b1;
      w       = $urandom;
      data_in = w;
      step();
      total++;
      if (data_out !== ref_encode(w)) begin
         bad++;
         $display("FAIL post_reset_launch got=%h want=%h", data_out, ref_encode(w));
      end
      $display("midreset: relaunch data_in=%h data_out=%h", w, data_out);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      valid   = 1'b0;
      data_in = '0;
      forced  = '0;
      test_reset();
      test_zero();
      test_all_ones();
      test_back_to_back();
      test_hold();
      test_random();
      test_force();
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
